// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC unit.
// Holds branch-condition codes, FSM state encodings and default vectors.
package npc_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLEZ = 3'b010;
  localparam logic [2:0] BR_BGTZ = 3'b011;
  localparam logic [2:0] BR_BLTZ = 3'b100;
  localparam logic [2:0] BR_BGEZ = 3'b101;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } npc_st_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/npc_br_cmp.sv
// Combinational branch-condition evaluator (signed 32-bit compares).
// Ports: br_op, rs_val, rt_val in; taken out (codes 11x never taken).
module npc_br_cmp
  import npc_pkg::*;
(
  input  logic [2:0]  br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);

  logic neg;
  logic zero;

  assign neg  = rs_val[31];
  assign zero = (rs_val == 32'd0);

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_BEQ:  taken = (rs_val == rt_val);
      BR_BNE:  taken = (rs_val != rt_val);
      BR_BLEZ: taken = neg | zero;
      BR_BGTZ: taken = ~neg & ~zero;
      BR_BLTZ: taken = neg;
      BR_BGEZ: taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_pipe.sv
// Registered next-PC unit: fetch PC, branch/jump/jr redirect with a
// one-entry pending-redirect buffer used while fetch is stalled.
// Ports: clk, reset (sync, high), stall, br_en/br_op/rs_val/rt_val/imm16,
//   j_en/j_idx, jr_en/jr_target, id_pc in; pc, link_pc, redirect, pending out.
// Macro NPC_EXC_EN adds exc_req, eret, epc (exception entry/return).
module npc_pipe
  import npc_pkg::*;
#(
  parameter int          ADDR_W   = 32,
`ifdef NPC_EXC_EN
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
`endif
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_en,
  input  logic [2:0]        br_op,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic [15:0]       imm16,
  input  logic              j_en,
  input  logic [25:0]       j_idx,
  input  logic              jr_en,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [ADDR_W-1:0] id_pc,
`ifdef NPC_EXC_EN
  input  logic              exc_req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic              redirect,
  output logic              pending
);

  localparam int WW = (ADDR_W > 32) ? ADDR_W : 32;
  localparam logic [ADDR_W-1:0] RST_V = ADDR_W'(RESET_PC);

  npc_st_t           st, st_n;
  logic [ADDR_W-1:0] pend_tgt, pend_n;
  logic [ADDR_W-1:0] pc_n;
  logic              redir_n;

  logic              taken;
  logic              req;
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] tgt;
  logic signed [31:0] off32;
  logic [WW-1:0]     jw;

  npc_br_cmp u_cmp (
    .br_op  (br_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .taken  (taken)
  );

  assign pc4     = id_pc + ADDR_W'(4);
  assign link_pc = id_pc + ADDR_W'(8);
  assign off32   = {{14{imm16[15]}}, imm16, 2'b00};
  // signed cast sign-extends when ADDR_W exceeds 32
  assign br_tgt  = pc4 + ADDR_W'(off32);

  always_comb begin
    jw       = WW'(pc4);
    jw[27:0] = {j_idx, 2'b00};
  end
  assign j_tgt = jw[ADDR_W-1:0];

  // jr beats j beats a taken branch
  assign req = jr_en | j_en | (br_en & taken);
  assign tgt = jr_en ? jr_target :
               j_en  ? j_tgt     : br_tgt;

  assign pending = (st == ST_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= ST_RUN;
      pc       <= RST_V;
      pend_tgt <= '0;
      redirect <= 1'b0;
    end else begin
      st       <= st_n;
      pc       <= pc_n;
      pend_tgt <= pend_n;
      redirect <= redir_n;
    end
  end

  always_comb begin
    st_n    = st;
    pc_n    = pc;
    pend_n  = pend_tgt;
    redir_n = 1'b0;
    case (st)
      ST_RUN: begin
        if (!stall) begin
          if (req) begin
            pc_n    = tgt;
            redir_n = 1'b1;
          end else begin
            pc_n = pc + ADDR_W'(4);
          end
        end else if (req) begin
          pend_n = tgt;
          st_n   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // later requests are dropped: the buffered one is older
        if (!stall) begin
          pc_n    = pend_tgt;
          redir_n = 1'b1;
          st_n    = ST_RUN;
        end
      end
      default: st_n = ST_RUN;
    endcase
`ifdef NPC_EXC_EN
    if (exc_req) begin
      pc_n    = ADDR_W'(EXC_PC);
      redir_n = 1'b1;
      pend_n  = '0;
      st_n    = ST_RUN;
    end else if (eret) begin
      pc_n    = epc;
      redir_n = 1'b1;
      pend_n  = '0;
      st_n    = ST_RUN;
    end
`endif
  end

endmodule

// File: tb/tb_npc_pipe.sv
// Scoreboard bench for npc_pipe: directed vectors push expected state,
// a monitor after each rising edge pops and compares pc/redirect/pending.
module tb_npc_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [2:0]  br_op = 3'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [15:0] imm16 = '0;
  logic        j_en = 1'b0;
  logic [25:0] j_idx = '0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] id_pc = '0;
`ifdef NPC_EXC_EN
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
`endif
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        redirect;
  logic        pending;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        r;
    logic        p;
    logic        cl;
    logic [31:0] lk;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  npc_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_en     (br_en),
    .br_op     (br_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .imm16     (imm16),
    .j_en      (j_en),
    .j_idx     (j_idx),
    .jr_en     (jr_en),
    .jr_target (jr_target),
    .id_pc     (id_pc),
`ifdef NPC_EXC_EN
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
`endif
    .pc        (pc),
    .link_pc   (link_pc),
    .redirect  (redirect),
    .pending   (pending)
  );

  task automatic clr();
    reset = 0; stall = 0; br_en = 0; br_op = 0;
    rs_val = 0; rt_val = 0; imm16 = 0; j_en = 0;
    j_idx = 0; jr_en = 0; jr_target = 0; id_pc = 0;
`ifdef NPC_EXC_EN
    exc_req = 0; eret = 0; epc = 0;
`endif
  endtask

  task automatic push(input string nm, input logic [31:0] p,
                      input logic r, input logic pd,
                      input logic cl = 1'b0,
                      input logic [31:0] lk = 32'h0);
    exp_t e;
    e.nm = nm; e.pc = p; e.r = r; e.p = pd; e.cl = cl; e.lk = lk;
    sbq.push_back(e);
  endtask

  task automatic br(input logic [2:0] op, input logic [31:0] rs,
                    input logic [31:0] rt);
    br_en = 1; br_op = op; rs_val = rs; rt_val = rt;
    id_pc = 32'h3004; imm16 = 16'hFFFE;
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      if (pc !== e.pc || redirect !== e.r || pending !== e.p ||
          (e.cl && link_pc !== e.lk)) begin
        bad++;
        $display("FAIL %s: pc=%h redir=%b pend=%b link=%h want pc=%h redir=%b pend=%b link=%h",
                 e.nm, pc, redirect, pending, link_pc,
                 e.pc, e.r, e.p, e.lk);
      end
    end
  end

  initial begin
    @(negedge clk); clr(); reset = 1; push("rst0", 32'h3000, 0, 0);
    @(negedge clk); clr(); reset = 1; push("rst1", 32'h3000, 0, 0);
    @(negedge clk); clr(); push("seq1", 32'h3004, 0, 0);
    @(negedge clk); clr(); push("seq2", 32'h3008, 0, 0);
    @(negedge clk); clr(); push("seq3", 32'h300C, 0, 0);
    @(negedge clk); clr(); push("seq4", 32'h3010, 0, 0);
    @(negedge clk); clr(); br(3'b000, 5, 5);
    push("beq_t", 32'h3000, 1, 0);
    @(negedge clk); clr(); push("post_beq", 32'h3004, 0, 0);
    @(negedge clk); clr(); br(3'b000, 5, 6);
    push("beq_nt", 32'h3008, 0, 0);
    @(negedge clk); clr(); br(3'b100, 32'h8000_0000, 0);
    push("bltz_t", 32'h3000, 1, 0);
    @(negedge clk); clr(); br(3'b101, 32'h8000_0000, 0);
    push("bgez_nt", 32'h3004, 0, 0);
    @(negedge clk); clr(); br(3'b010, 32'h8000_0000, 0);
    push("blez_neg_t", 32'h3000, 1, 0);
    @(negedge clk); clr(); br(3'b011, 32'h8000_0000, 0);
    push("bgtz_neg_nt", 32'h3004, 0, 0);
    @(negedge clk); clr(); br(3'b010, 0, 0);
    push("blez_0_t", 32'h3000, 1, 0);
    @(negedge clk); clr(); br(3'b011, 0, 0);
    push("bgtz_0_nt", 32'h3004, 0, 0);
    @(negedge clk); clr(); br(3'b001, 5, 6);
    push("bne_t", 32'h3000, 1, 0);
    @(negedge clk); clr(); br(3'b110, 5, 5);
    push("op110_nt", 32'h3004, 0, 0);
    // stalled jr goes to HOLD; a j during HOLD and at release is dropped
    @(negedge clk); clr(); stall = 1; jr_en = 1; jr_target = 32'h3100;
    push("hold_in", 32'h3004, 0, 1);
    @(negedge clk); clr(); stall = 1;
    push("hold_1", 32'h3004, 0, 1);
    @(negedge clk); clr(); stall = 1; j_en = 1;
    id_pc = 32'h3FFC; j_idx = 26'h0000C40;
    push("hold_j", 32'h3004, 0, 1);
    @(negedge clk); clr(); j_en = 1; id_pc = 32'h3FFC;
    j_idx = 26'h0000008;
    push("hold_rel", 32'h3100, 1, 0);
    @(negedge clk); clr(); push("post_rel", 32'h3104, 0, 0);
    @(negedge clk); clr(); j_en = 1; id_pc = 32'h3FFC;
    j_idx = 26'h0000C40;
    push("jal", 32'h3100, 1, 0, 1, 32'h4004);
    @(negedge clk); clr(); br(3'b000, 5, 5); jr_en = 1;
    jr_target = 32'h5000;
    push("jr_over_br", 32'h5000, 1, 0);
    @(negedge clk); clr(); br(3'b000, 5, 5); j_en = 1;
    id_pc = 32'h3FFC; j_idx = 26'h0000C40;
    push("j_over_br", 32'h3100, 1, 0);
    @(negedge clk); clr(); push("idle", 32'h3104, 0, 0);
    @(negedge clk); clr(); jr_en = 1; jr_target = 32'hFFFF_FFFC;
    push("jr_top", 32'hFFFF_FFFC, 1, 0);
    @(negedge clk); clr(); push("wrap", 32'h0000_0000, 0, 0);
    @(negedge clk); clr(); stall = 1; jr_en = 1; jr_target = 32'h3100;
    push("hold2_in", 32'h0, 0, 1);
    @(negedge clk); clr(); stall = 1; reset = 1;
    push("rst_hold", 32'h3000, 0, 0);
    @(negedge clk); clr(); push("after_rst", 32'h3004, 0, 0);
`ifdef NPC_EXC_EN
    @(negedge clk); clr(); stall = 1; jr_en = 1; jr_target = 32'h3200;
    push("x_hold", 32'h3004, 0, 1);
    @(negedge clk); clr(); stall = 1; exc_req = 1;
    push("x_exc", 32'h4180, 1, 0);
    @(negedge clk); clr(); stall = 1;
    push("x_stall", 32'h4180, 0, 0);
    @(negedge clk); clr(); eret = 1; epc = 32'h3008;
    push("x_eret", 32'h3008, 1, 0);
    @(negedge clk); clr(); reset = 1; exc_req = 1;
    push("x_rst_exc", 32'h3000, 0, 0);
`endif
    @(negedge clk); clr();
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
